// File: rtl/arbitro_de_funcionalidade.sv
// Purpose: arbitrates the shared LED output resource between two users. Both users
//          are granted when their functionality codes differ, otherwise one wins.
// Latency: 1 cycle from request to registered grant. No backpressure: inputs are sampled every cycle.
//
// Ports:
//   CLK, RST_N              clock (rising edge), async active-low reset
//   USER0/1  [2:0]          user codes, a larger value means higher priority
//   FUNC0/1  [2:0]          functionality codes, 000 means no request
//   GNT      [1:0]          bit i = user i owns the resource
//   FUNC_ATIVA0/1 [2:0]     FUNCi gated by the grant, for the functionality decoders
//   USER_BLOQ [2:0], BLOQ_VALID   code of the user being denied, and its valid flag
//   TROCA                   one-cycle pulse after any change of GNT
module arbitro_de_funcionalidade #(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 32,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] USER0,
    input  logic [2:0] FUNC0,
    input  logic [2:0] USER1,
    input  logic [2:0] FUNC1,
    output logic [1:0] GNT,
    output logic [2:0] FUNC_ATIVA0,
    output logic [2:0] FUNC_ATIVA1,
    output logic [2:0] USER_BLOQ,
    output logic       BLOQ_VALID,
    output logic       TROCA
);

    typedef enum logic [1:0] {IDLE, SERV0, SERV1, AMBOS} state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);

    state_t           state;
    state_t           state_nxt;
    state_t           decided;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last;      // 0 = user 0 was the last single holder, 1 = user 1
    logic             req0;
    logic             req1;
    logic [1:0]       gnt_nxt;

    assign req0 = (FUNC0 != 3'b000);
    assign req1 = (FUNC1 != 3'b000);

    // Fresh arbitration over the current requests, ignoring any hold.
    always_comb begin
        decided = IDLE;
        if (req0 && req1) begin
            if (FUNC0 != FUNC1)
                decided = AMBOS;
            else if (USER0 > USER1)
                decided = SERV0;
            else if (USER1 > USER0)
                decided = SERV1;
            else
                decided = last ? SERV0 : SERV1;   // tie: whoever did not hold last
        end else if (req0) begin
            decided = SERV0;
        end else if (req1) begin
            decided = SERV1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = decided;
            SERV0: begin
                if (!req0)
                    state_nxt = decided;
                else if (cnt >= MIN_C) begin
                    // FUNC equality implies the other user is requesting, since req0 holds
                    if (req1 && (FUNC1 != FUNC0))
                        state_nxt = AMBOS;
                    else if ((FUNC1 == FUNC0) && (USER1 > USER0))
                        state_nxt = SERV1;
                    else if ((FUNC1 == FUNC0) && (USER1 == USER0) && (cnt == MAX_C))
                        state_nxt = SERV1;
                end
            end
            SERV1: begin
                if (!req1)
                    state_nxt = decided;
                else if (cnt >= MIN_C) begin
                    if (req0 && (FUNC0 != FUNC1))
                        state_nxt = AMBOS;
                    else if ((FUNC0 == FUNC1) && (USER0 > USER1))
                        state_nxt = SERV0;
                    else if ((FUNC0 == FUNC1) && (USER0 == USER1) && (cnt == MAX_C))
                        state_nxt = SERV0;
                end
            end
            AMBOS: begin
                // a release or a collision of FUNCs is resolved at once, no hold
                if (!req0 || !req1 || (FUNC0 == FUNC1))
                    state_nxt = decided;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_nxt = {(state_nxt == SERV1) || (state_nxt == AMBOS),
                      (state_nxt == SERV0) || (state_nxt == AMBOS)};

    always_comb begin
        cnt_nxt = cnt;
        if ((state_nxt != state) && (state_nxt != IDLE))
            cnt_nxt = '0;
        else if (cnt < MAX_C)
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            GNT         <= 2'b00;
            FUNC_ATIVA0 <= 3'b000;
            FUNC_ATIVA1 <= 3'b000;
            USER_BLOQ   <= 3'b000;
            BLOQ_VALID  <= 1'b0;
            TROCA       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            if (state_nxt == SERV0)
                last <= 1'b0;
            else if (state_nxt == SERV1)
                last <= 1'b1;
            GNT         <= gnt_nxt;
            TROCA       <= (gnt_nxt != GNT);
            FUNC_ATIVA0 <= gnt_nxt[0] ? FUNC0 : 3'b000;
            FUNC_ATIVA1 <= gnt_nxt[1] ? FUNC1 : 3'b000;
            if ((state_nxt == SERV0) && req1) begin
                USER_BLOQ  <= USER1;
                BLOQ_VALID <= 1'b1;
            end else if ((state_nxt == SERV1) && req0) begin
                USER_BLOQ  <= USER0;
                BLOQ_VALID <= 1'b1;
            end else begin
                USER_BLOQ  <= 3'b000;
                BLOQ_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_de_funcionalidade.sv
module tb_arbitro_de_funcionalidade;

    localparam int MIN_H = 4;
    localparam int MAX_H = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] USER0 = 3'b000, FUNC0 = 3'b000, USER1 = 3'b000, FUNC1 = 3'b000;
    logic [1:0] GNT;
    logic [2:0] FUNC_ATIVA0, FUNC_ATIVA1, USER_BLOQ;
    logic       BLOQ_VALID, TROCA;

    int checks = 0;
    int failures = 0;

    arbitro_de_funcionalidade #(.MIN_HOLD(MIN_H), .MAX_HOLD(MAX_H), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .USER0(USER0), .FUNC0(FUNC0), .USER1(USER1), .FUNC1(FUNC1),
        .GNT(GNT), .FUNC_ATIVA0(FUNC_ATIVA0), .FUNC_ATIVA1(FUNC_ATIVA1),
        .USER_BLOQ(USER_BLOQ), .BLOQ_VALID(BLOQ_VALID), .TROCA(TROCA)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model: grant mask + hold age ----------------
    logic [1:0] m_g;          // set of granted users
    int         m_age;        // cycles since the current grant set was established
    int         m_last;       // last single holder index
    logic [1:0] m_ng;
    logic [2:0] m_fa0, m_fa1, m_ub;
    logic       m_bv, m_tr;

    function automatic logic [1:0] pick(logic [2:0] u0, logic [2:0] f0,
                                        logic [2:0] u1, logic [2:0] f1, int last);
        if (f0 == 0 && f1 == 0) return 2'b00;
        if (f1 == 0) return 2'b01;
        if (f0 == 0) return 2'b10;
        if (f0 != f1) return 2'b11;
        if (u0 > u1) return 2'b01;
        if (u1 > u0) return 2'b10;
        return (last == 0) ? 2'b10 : 2'b01;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_g = 0; m_age = 0; m_last = 1;
            m_fa0 = 0; m_fa1 = 0; m_ub = 0; m_bv = 0; m_tr = 0;
        end else begin
            logic [2:0] fh, fo, uh, uo;
            m_ng = m_g;
            if (m_g == 2'b00) begin
                m_ng = pick(USER0, FUNC0, USER1, FUNC1, m_last);
            end else if (m_g == 2'b11) begin
                if (FUNC0 == 0 || FUNC1 == 0 || FUNC0 == FUNC1)
                    m_ng = pick(USER0, FUNC0, USER1, FUNC1, m_last);
            end else begin
                fh = (m_g == 2'b01) ? FUNC0 : FUNC1;
                uh = (m_g == 2'b01) ? USER0 : USER1;
                fo = (m_g == 2'b01) ? FUNC1 : FUNC0;
                uo = (m_g == 2'b01) ? USER1 : USER0;
                if (fh == 0)
                    m_ng = pick(USER0, FUNC0, USER1, FUNC1, m_last);
                else if (m_age >= MIN_H) begin
                    if (fo != 0 && fo != fh) m_ng = 2'b11;
                    else if (fo == fh && uo > uh) m_ng = ~m_g;
                    else if (fo == fh && uo == uh && m_age == MAX_H) m_ng = ~m_g;
                end
            end
            if (m_ng != 0 && m_ng != m_g) m_age = 0;
            else if (m_age < MAX_H) m_age = m_age + 1;
            if (m_ng == 2'b01) m_last = 0;
            if (m_ng == 2'b10) m_last = 1;
            m_tr  = (m_ng != m_g);
            m_fa0 = (m_ng == 2'b01 || m_ng == 2'b11) ? FUNC0 : 3'b000;
            m_fa1 = (m_ng == 2'b10 || m_ng == 2'b11) ? FUNC1 : 3'b000;
            if (m_ng == 2'b01 && FUNC1 != 0)      begin m_ub = USER1; m_bv = 1; end
            else if (m_ng == 2'b10 && FUNC0 != 0) begin m_ub = USER0; m_bv = 1; end
            else                                   begin m_ub = 0;     m_bv = 0; end
            m_g = m_ng;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        USER0 = 0; FUNC0 = 0; USER1 = 0; FUNC1 = 0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        USER1 = 3'b001; FUNC1 = 3'b001;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b10) begin
            failures++; $display("FAIL reset_pre_serv1 GNT=%b expected 10", GNT);
        end
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (GNT !== 2'b00 || FUNC_ATIVA1 !== 3'b000 || BLOQ_VALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_async GNT=%b FA1=%b BV=%b expected 00 000 0", GNT, FUNC_ATIVA1, BLOQ_VALID);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({GNT, FUNC_ATIVA0, FUNC_ATIVA1, USER_BLOQ, BLOQ_VALID, TROCA} !== 13'd0) begin
                failures++;
                $display("FAIL reset_hold GNT=%b FA0=%b FA1=%b UB=%b BV=%b TR=%b expected all zero",
                         GNT, FUNC_ATIVA0, FUNC_ATIVA1, USER_BLOQ, BLOQ_VALID, TROCA);
            end
        end
        RST_N = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        USER0 = 3'b101; FUNC0 = 3'b001; FUNC1 = 3'b000;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b01 || FUNC_ATIVA0 !== 3'b001 || TROCA !== 1'b1) begin
            failures++;
            $display("FAIL single_grant GNT=%b FA0=%b TR=%b expected 01 001 1", GNT, FUNC_ATIVA0, TROCA);
        end
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b01 || TROCA !== 1'b0) begin
            failures++; $display("FAIL single_pulse GNT=%b TR=%b expected 01 0", GNT, TROCA);
        end
    endtask

    task automatic test_priority();
        do_reset();
        USER0 = 3'b101; FUNC0 = 3'b001; USER1 = 3'b001; FUNC1 = 3'b001;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b01 || USER_BLOQ !== 3'b001 || BLOQ_VALID !== 1'b1) begin
            failures++;
            $display("FAIL priority GNT=%b UB=%b BV=%b expected 01 001 1", GNT, USER_BLOQ, BLOQ_VALID);
        end
    endtask

    task automatic test_diff_func();
        do_reset();
        USER0 = 3'b101; FUNC0 = 3'b010; USER1 = 3'b001; FUNC1 = 3'b001;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b11 || FUNC_ATIVA0 !== 3'b010 || FUNC_ATIVA1 !== 3'b001 || BLOQ_VALID !== 1'b0) begin
            failures++;
            $display("FAIL ambos GNT=%b FA0=%b FA1=%b BV=%b expected 11 010 001 0",
                     GNT, FUNC_ATIVA0, FUNC_ATIVA1, BLOQ_VALID);
        end
        FUNC0 = 3'b001;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b01 || FUNC_ATIVA1 !== 3'b000 || TROCA !== 1'b1 || USER_BLOQ !== 3'b001) begin
            failures++;
            $display("FAIL ambos_collide GNT=%b FA1=%b TR=%b UB=%b expected 01 000 1 001",
                     GNT, FUNC_ATIVA1, TROCA, USER_BLOQ);
        end
    endtask

    task automatic test_rotation();
        int bad = 0;
        logic [1:0] exp_g;
        @(negedge CLK);
        RST_N = 1'b0;
        USER0 = 3'b001; USER1 = 3'b001; FUNC0 = 3'b011; FUNC1 = 3'b011;
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge CLK);
            exp_g = (((k / 9) % 2) == 0) ? 2'b01 : 2'b10;
            checks++;
            if (GNT !== exp_g) begin
                failures++; $display("FAIL rotation cycle=%0d GNT=%b expected %b", k, GNT, exp_g);
            end
        end
    endtask

    task automatic test_hold_preempt();
        do_reset();
        USER1 = 3'b001; FUNC1 = 3'b001;
        @(negedge CLK);                     // entry edge seen, hold age 0
        USER0 = 3'b101; FUNC0 = 3'b001;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            checks++;
            if (GNT !== 2'b10 || USER_BLOQ !== 3'b101 || BLOQ_VALID !== 1'b1) begin
                failures++;
                $display("FAIL hold age=%0d GNT=%b UB=%b BV=%b expected 10 101 1", i, GNT, USER_BLOQ, BLOQ_VALID);
            end
        end
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b01 || TROCA !== 1'b1 || USER_BLOQ !== 3'b001) begin
            failures++; $display("FAIL preempt GNT=%b TR=%b UB=%b expected 01 1 001", GNT, TROCA, USER_BLOQ);
        end
        // early release by the holder overrides the hold
        do_reset();
        USER0 = 3'b000; FUNC0 = 3'b001; USER1 = 3'b001; FUNC1 = 3'b001;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b10) begin
            failures++; $display("FAIL release_entry GNT=%b expected 10", GNT);
        end
        @(negedge CLK);                     // hold age 1
        FUNC1 = 3'b000;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b01 || BLOQ_VALID !== 1'b0 || TROCA !== 1'b1) begin
            failures++; $display("FAIL release_switch GNT=%b BV=%b TR=%b expected 01 0 1", GNT, BLOQ_VALID, TROCA);
        end
        FUNC0 = 3'b000;
        @(negedge CLK);
        checks++;
        if (GNT !== 2'b00 || TROCA !== 1'b1 || FUNC_ATIVA0 !== 3'b000) begin
            failures++; $display("FAIL release_idle GNT=%b TR=%b FA0=%b expected 00 1 000", GNT, TROCA, FUNC_ATIVA0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 800; n++) begin
            @(negedge CLK);
            checks++;
            if (GNT !== m_g || TROCA !== m_tr) begin
                failures++;
                $display("FAIL rand_grant n=%0d GNT=%b TR=%b expected %b %b", n, GNT, TROCA, m_g, m_tr);
            end
            checks++;
            if (FUNC_ATIVA0 !== m_fa0 || FUNC_ATIVA1 !== m_fa1 || USER_BLOQ !== m_ub || BLOQ_VALID !== m_bv) begin
                failures++;
                $display("FAIL rand_out n=%0d FA0=%b FA1=%b UB=%b BV=%b expected %b %b %b %b",
                         n, FUNC_ATIVA0, FUNC_ATIVA1, USER_BLOQ, BLOQ_VALID, m_fa0, m_fa1, m_ub, m_bv);
            end
            if ($urandom_range(0, 9) < 3) FUNC0 = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) FUNC1 = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) USER0 = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) USER1 = 3'($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_diff_func();
        test_rotation();
        test_hold_preempt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
